// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and OAM DMA state encoding for the system bus.
`timescale 1ns/1ps
package gb_mem_pkg;

  localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
  localparam logic [15:0] OAM_END_ADDR  = 16'hFE9F;
  localparam int unsigned OAM_BYTES     = 160;
  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA writer: snoops FF46 writes and copies 160 source bytes into OAM
// on a fixed byte-slot cadence while holding DMA_ACTIVE for the bus arbiter.
`timescale 1ns/1ps
module oam_dma_ctrl
  import gb_mem_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic [7:0]  MMIO_DATA_out,
  output logic        DMA_RD,
  output logic [15:0] DMA_ADDR,
  input  logic [7:0]  DMA_DATA_in,
  output logic        OAM_WR,
  output logic [15:0] OAM_ADDR,
  output logic [7:0]  OAM_WDATA,
  output logic        DMA_ACTIVE
);

  localparam int unsigned PW = $clog2(CYCLES_PER_BYTE);
  localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [PW-1:0] LAST_PHASE = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [DW-1:0] LAST_DELAY = DW'(START_DELAY - 1);
  localparam logic [7:0]    LAST_INDEX = 8'(OAM_BYTES - 1);

  dma_state_t    state_q, state_d;
  logic [7:0]    src_hi_q, src_hi_d;
  logic [7:0]    index_q, index_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] delay_q, delay_d;

  logic trigger;
  assign trigger = WR && (ADDR == DMA_REG_ADDR);

  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    index_d  = index_q;
    phase_d  = phase_q;
    delay_d  = delay_q;
    if (trigger) begin
      // Echo RAM pages E0-FF alias work RAM C0-DF.
      src_hi_d = (MMIO_DATA_out >= 8'hE0) ? (MMIO_DATA_out & 8'hDF) : MMIO_DATA_out;
      index_d  = 8'd0;
      phase_d  = '0;
      delay_d  = '0;
      state_d  = DELAY;
    end else begin
      case (state_q)
        IDLE: ;
        DELAY: begin
          if (delay_q == LAST_DELAY) begin
            state_d = XFER;
            phase_d = '0;
          end else begin
            delay_d = delay_q + DW'(1);
          end
        end
        XFER: begin
          if (phase_q == LAST_PHASE) begin
            phase_d = '0;
            if (index_q == LAST_INDEX) begin
              state_d = IDLE;
              index_d = 8'd0;
            end else begin
              index_d = index_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_hi_q <= 8'd0;
      index_q  <= 8'd0;
      phase_q  <= '0;
      delay_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      index_q  <= index_d;
      phase_q  <= phase_d;
      delay_q  <= delay_d;
    end
  end

  // Addresses are zeroed whenever their strobe is low, which keeps them 0 in IDLE.
  always_comb begin
    DMA_RD     = (state_q == XFER) && (phase_q == PW'(0));
    OAM_WR     = (state_q == XFER) && (phase_q == PW'(1));
    DMA_ACTIVE = (state_q != IDLE);
    DMA_ADDR   = DMA_RD ? {src_hi_q, index_q} : 16'h0000;
    OAM_ADDR   = OAM_WR ? (OAM_BASE_ADDR + {8'h00, index_q}) : 16'h0000;
    OAM_WDATA  = OAM_WR ? DMA_DATA_in : 8'h00;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a source-memory model and OAM capture.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

  localparam int unsigned CPB = 4;
  localparam int unsigned SD  = 4;
  localparam int          TOTAL = SD + 160 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic        WR = 1'b0;
  logic [7:0]  MMIO_DATA_out = 8'h00;
  logic        DMA_RD;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DATA_in;
  logic        OAM_WR;
  logic [15:0] OAM_ADDR;
  logic [7:0]  OAM_WDATA;
  logic        DMA_ACTIVE;

  oam_dma_ctrl #(
    .CYCLES_PER_BYTE(CPB),
    .START_DELAY    (SD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ADDR         (ADDR),
    .WR           (WR),
    .MMIO_DATA_out(MMIO_DATA_out),
    .DMA_RD       (DMA_RD),
    .DMA_ADDR     (DMA_ADDR),
    .DMA_DATA_in  (DMA_DATA_in),
    .OAM_WR       (OAM_WR),
    .OAM_ADDR     (OAM_ADDR),
    .OAM_WDATA    (OAM_WDATA),
    .DMA_ACTIVE   (DMA_ACTIVE)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [7:0]  oam [0:159];
  logic [7:0]  rd_data = 8'h00;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] last_rd_addr = 16'h0000;
  logic [15:0] last_oam_addr = 16'h0000;
  logic        bad_oam = 1'b0;

  int checks = 0;
  int errors = 0;

  assign DMA_DATA_in = rd_data;

  // Source memory answers one clock after DMA_RD; OAM writes land in the capture array.
  always @(posedge clk) begin
    rd_data <= mem[DMA_ADDR];
    if (DMA_RD) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= DMA_ADDR;
    end
    if (OAM_WR) begin
      wr_cnt        <= wr_cnt + 1;
      last_oam_addr <= OAM_ADDR;
      if (OAM_ADDR >= 16'hFE00 && OAM_ADDR <= 16'hFE9F) oam[OAM_ADDR - 16'hFE00] <= OAM_WDATA;
      else bad_oam <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_trigger(input logic [7:0] data);
    ADDR = 16'hFF46;
    WR = 1'b1;
    MMIO_DATA_out = data;
    tick();
    WR = 1'b0;
    ADDR = 16'h0000;
    MMIO_DATA_out = 8'h00;
  endtask

  // Starts at clock 0 after the trigger edge; counts clocks with DMA_ACTIVE high.
  task automatic run_xfer(input string tag, input logic [15:0] first_addr, output int n);
    n = 0;
    while (DMA_ACTIVE === 1'b1 && n < 2000) begin
      if (n < SD) check({tag, "_no_rd_in_delay"}, {31'd0, DMA_RD}, 32'd0);
      if (n == SD) begin
        check({tag, "_first_rd"}, {31'd0, DMA_RD}, 32'd1);
        check({tag, "_first_addr"}, {16'd0, DMA_ADDR}, {16'd0, first_addr});
      end
      if (n == SD + 1) begin
        check({tag, "_first_wr"}, {31'd0, OAM_WR}, 32'd1);
        check({tag, "_first_oam_addr"}, {16'd0, OAM_ADDR}, 32'h0000FE00);
        check({tag, "_first_wdata"}, {24'd0, OAM_WDATA}, {24'd0, mem[first_addr]});
      end
      n++;
      tick();
    end
    check({tag, "_active_len"}, n, TOTAL);
  endtask

  task automatic check_oam(input string tag, input logic [15:0] base);
    int bad = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== mem[base + 16'(i)]) bad++;
    check({tag, "_oam_contents"}, bad, 32'd0);
  endtask

  int n;
  int base_rd;
  int base_wr;
  int w;
  logic drop;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'hC3;
      mem[16'hD000 + 16'(i)] = 8'(i * 3) ^ 8'h11;
      oam[i] = 8'h00;
    end

    #3;
    check("reset_active", {31'd0, DMA_ACTIVE}, 32'd0);
    check("reset_rd", {31'd0, DMA_RD}, 32'd0);
    check("reset_wr", {31'd0, OAM_WR}, 32'd0);
    check("reset_dma_addr", {16'd0, DMA_ADDR}, 32'd0);
    check("reset_oam_addr", {16'd0, OAM_ADDR}, 32'd0);
    check("reset_wdata", {24'd0, OAM_WDATA}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Writes to neighbouring registers must not start a transfer.
    base_rd = rd_cnt;
    base_wr = wr_cnt;
    drop = 1'b0;
    ADDR = 16'hFF45; WR = 1'b1; MMIO_DATA_out = 8'hC0; tick();
    ADDR = 16'hFF47; tick();
    WR = 1'b0; ADDR = 16'h0000; MMIO_DATA_out = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (DMA_ACTIVE !== 1'b0) drop = 1'b1;
      tick();
    end
    check("nontrig_active", {31'd0, drop}, 32'd0);
    check("nontrig_rd", rd_cnt - base_rd, 32'd0);
    check("nontrig_wr", wr_cnt - base_wr, 32'd0);

    // Basic copy from C000.
    base_rd = rd_cnt;
    base_wr = wr_cnt;
    do_trigger(8'hC0);
    check("basic_active_rise", {31'd0, DMA_ACTIVE}, 32'd1);
    run_xfer("basic", 16'hC000, n);
    check("basic_rd_count", rd_cnt - base_rd, 32'd160);
    check("basic_wr_count", wr_cnt - base_wr, 32'd160);
    check("basic_last_oam_addr", {16'd0, last_oam_addr}, 32'h0000FE9F);
    check("basic_last_rd_addr", {16'd0, last_rd_addr}, 32'h0000C09F);
    check("basic_idle_oam_addr", {16'd0, OAM_ADDR}, 32'd0);
    check_oam("basic", 16'hC000);

    // Echo fold: E1 reads from C1xx.
    base_wr = wr_cnt;
    do_trigger(8'hE1);
    run_xfer("echo", 16'hC100, n);
    check("echo_wr_count", wr_cnt - base_wr, 32'd160);
    check("echo_last_rd_addr", {16'd0, last_rd_addr}, 32'h0000C19F);
    check_oam("echo", 16'hC100);

    // Restart partway through with a new source.
    do_trigger(8'hC0);
    base_wr = wr_cnt;
    drop = 1'b0;
    w = 0;
    while ((wr_cnt - base_wr) < 50 && w < 2000) begin
      if (DMA_ACTIVE !== 1'b1) drop = 1'b1;
      w++;
      tick();
    end
    check("restart_reached_50", {31'd0, (wr_cnt - base_wr) >= 50}, 32'd1);
    check("restart_active_cont", {31'd0, drop}, 32'd0);
    do_trigger(8'hD0);
    run_xfer("restart", 16'hD000, n);
    check("restart_last_oam_addr", {16'd0, last_oam_addr}, 32'h0000FE9F);
    check_oam("restart", 16'hD000);

    // Asynchronous reset in the middle of a copy, on a DMA_RD clock.
    do_trigger(8'hC0);
    base_wr = wr_cnt;
    w = 0;
    while ((wr_cnt - base_wr) < 80 && w < 2000) begin w++; tick(); end
    while (DMA_RD !== 1'b1 && w < 2000) begin w++; tick(); end
    check("rstmid_rd_before", {31'd0, DMA_RD}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_active", {31'd0, DMA_ACTIVE}, 32'd0);
    check("rstmid_rd", {31'd0, DMA_RD}, 32'd0);
    check("rstmid_wr", {31'd0, OAM_WR}, 32'd0);
    check("rstmid_dma_addr", {16'd0, DMA_ADDR}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    base_rd = rd_cnt;
    base_wr = wr_cnt;
    drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (DMA_ACTIVE !== 1'b0) drop = 1'b1;
      tick();
    end
    check("rstmid_no_active", {31'd0, drop}, 32'd0);
    check("rstmid_no_rd", rd_cnt - base_rd, 32'd0);
    check("rstmid_no_wr", wr_cnt - base_wr, 32'd0);
    base_wr = wr_cnt;
    do_trigger(8'hC0);
    run_xfer("after_rst", 16'hC000, n);
    check("after_rst_wr_count", wr_cnt - base_wr, 32'd160);
    check_oam("after_rst", 16'hC000);

    tick();
    check("never_outside_oam", {31'd0, bad_oam}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
